// File: rtl/waverforms_mul_pipe_hs.sv
// waverforms_mul_pipe_hs
// Pipelined multiplier with a valid/ready handshake for the waveform datapath.
// Operand signedness, widths, output shift and pipeline depth are set per
// instance. Every slot advances when the slot after it is empty or advancing,
// so bubbles collapse and backpressure is absorbed without losing or
// duplicating samples.
//
// Build option: define WAVERFORMS_MUL_SAT_EN to clamp out-of-range results to
// the dout range and flag them on ovf. Without it the result wraps to the low
// dout_WIDTH bits and ovf is tied low.
module waverforms_mul_pipe_hs #(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 30,
    parameter int din1_WIDTH  = 29,
    parameter int dout_WIDTH  = 58,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0,
    parameter int SHIFT       = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf,
    output logic                  busy
);

    localparam int P  = din0_WIDTH + din1_WIDTH;
    localparam bit RS = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
    // Working width for narrowing: wide enough for both the scaled product and
    // the dout limits, plus headroom so the limits are representable as signed.
    localparam int EW = ((P + 1 > dout_WIDTH) ? P + 1 : dout_WIDTH) + 2;

`ifdef WAVERFORMS_MUL_SAT_EN
    localparam logic signed [EW-1:0] ONE = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] HI  = RS ? (ONE <<< (dout_WIDTH - 1)) - ONE
                                              : (ONE <<< dout_WIDTH) - ONE;
    localparam logic signed [EW-1:0] LO  = RS ? -(ONE <<< (dout_WIDTH - 1))
                                              : {EW{1'b0}};
    // When dout is wide enough for every shifted product the clamp can never fire.
    localparam bit NO_OVF = dout_WIDTH >= (P - SHIFT + (RS ? 1 : 0));
`endif

    // Exact product in P+1 bits followed by the output shift. Unsigned operands
    // gain a zero MSB so the whole multiply is done as signed arithmetic.
    function automatic logic signed [P:0] scale(input logic [din0_WIDTH-1:0] a,
                                                input logic [din1_WIDTH-1:0] b);
        logic signed [din0_WIDTH:0] ae;
        logic signed [din1_WIDTH:0] be;
        logic signed [P:0]          full;
        ae   = (DIN0_SIGNED != 0) ? $signed({a[din0_WIDTH-1], a}) : $signed({1'b0, a});
        be   = (DIN1_SIGNED != 0) ? $signed({b[din1_WIDTH-1], b}) : $signed({1'b0, b});
        full = (P+1)'(ae) * (P+1)'(be);
        if (RS)
            return full >>> SHIFT;
        else
            return $signed(full >> SHIFT);
    endfunction

    // Narrow the scaled product to dout_WIDTH: clamp when saturation is built
    // in, otherwise keep the low bits.
    function automatic logic [dout_WIDTH-1:0] narrow(input logic signed [P:0] s);
        logic signed [EW-1:0] v;
        v = EW'(s);
`ifdef WAVERFORMS_MUL_SAT_EN
        if (!NO_OVF) begin
            if (v > HI) return HI[dout_WIDTH-1:0];
            if (v < LO) return LO[dout_WIDTH-1:0];
        end
`endif
        return v[dout_WIDTH-1:0];
    endfunction

`ifdef WAVERFORMS_MUL_SAT_EN
    // Overflow flag matching the clamp decision in narrow().
    function automatic logic over(input logic signed [P:0] s);
        logic signed [EW-1:0] v;
        v = EW'(s);
        if (NO_OVF) return 1'b0;
        return (v > HI) || (v < LO);
    endfunction
`endif

    logic [NUM_STAGE-1:0] vld;
    logic [NUM_STAGE-1:0] vld_in;
    logic [NUM_STAGE-1:0] can_load;
    logic signed [P:0]    scaled_last;

    // Valid bit offered to each slot: the input for slot 0, the previous slot otherwise.
    if (NUM_STAGE == 1) begin : g_vin1
        assign vld_in = in_valid;
    end else begin : g_vinn
        assign vld_in = {vld[NUM_STAGE-2:0], in_valid};
    end

    // A slot may load when any slot from it to the output is empty, or the output drains.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        can_load  = '0;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            full_tail   = full_tail & vld[k];
            can_load[k] = out_ready | ~full_tail;
        end
    end

    assign in_ready  = can_load[0];
    assign out_valid = vld[NUM_STAGE-1];
    assign busy      = |vld;

    // Slot occupancy: each loading slot takes the valid bit offered to it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            vld <= '0;
        else
            vld <= (can_load & vld_in) | (~can_load & vld);
    end

    if (NUM_STAGE == 1) begin : g_s1
        assign scaled_last = scale(din0, din1);
    end else begin : g_sn
        logic [din0_WIDTH-1:0] a_p0;
        logic [din1_WIDTH-1:0] b_p0;

        // stage 1: capture operands
        always_ff @(posedge ap_clk) begin
            if (can_load[0] && in_valid) begin
                a_p0 <= din0;
                b_p0 <= din1;
            end
        end

        if (NUM_STAGE == 2) begin : g_s2
            assign scaled_last = scale(a_p0, b_p0);
        end else begin : g_s3
            logic signed [P:0] prod_p  [NUM_STAGE-2];
            logic signed [P:0] prod_in [NUM_STAGE-2];

            // Input of each product slot: fresh product for the first, the previous slot after.
            always_comb begin
                prod_in[0] = scale(a_p0, b_p0);
                for (int k = 1; k < NUM_STAGE - 2; k++)
                    prod_in[k] = prod_p[k-1];
            end

            // stages 2..NUM_STAGE-1: scaled product, then carried toward the output
            always_ff @(posedge ap_clk) begin
                for (int k = 0; k < NUM_STAGE - 2; k++)
                    if (can_load[k+1] && vld[k])
                        prod_p[k] <= prod_in[k];
            end

            assign scaled_last = prod_p[NUM_STAGE-3];
        end
    end

    // last stage: narrowed result, cleared on reset so an idle output reads zero
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            dout <= '0;
        else if (can_load[NUM_STAGE-1] && vld_in[NUM_STAGE-1])
            dout <= narrow(scaled_last);
    end

`ifdef WAVERFORMS_MUL_SAT_EN
    // last stage: overflow flag travels with its result
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            ovf <= 1'b0;
        else if (can_load[NUM_STAGE-1] && vld_in[NUM_STAGE-1])
            ovf <= over(scaled_last);
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_waverforms_mul_pipe_hs.sv
// Self-checking bench for waverforms_mul_pipe_hs: a default instance plus a
// narrow-output instance and a shifted signed-by-signed instance, all driven
// from the same stimulus and checked against a queue-based scoreboard.
module tb_waverforms_mul_pipe_hs;

    logic        clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [29:0] din0;
    logic [28:0] din1;

    logic        in_ready, out_valid, ovf, busy;
    logic [57:0] dout;
    logic        n_in_ready, n_out_valid, n_ovf, n_busy;
    logic [56:0] n_dout;
    logic        s_in_ready, s_out_valid, s_ovf, s_busy;
    logic [57:0] s_dout;

    int errors = 0;
    int checks = 0;
    logic acc;

    logic [58:0] qm[$];
    logic [57:0] qn[$];
    logic [58:0] qs[$];
    logic        prev_stall = 1'b0;
    logic [57:0] prev_dout  = '0;

    always #5 clk = ~clk;

    waverforms_mul_pipe_hs u_dut (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .ovf(ovf), .busy(busy)
    );

    waverforms_mul_pipe_hs #(.dout_WIDTH(57)) u_nar (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
        .din0(din0), .din1(din1), .out_valid(n_out_valid), .out_ready(out_ready),
        .dout(n_dout), .ovf(n_ovf), .busy(n_busy)
    );

    waverforms_mul_pipe_hs #(.SHIFT(4), .DIN1_SIGNED(1)) u_sh (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .din0(din0), .din1(din1), .out_valid(s_out_valid), .out_ready(out_ready),
        .dout(s_dout), .ovf(s_ovf), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {ovf, dout} for the default instance (signed x unsigned, 58-bit out).
    function automatic logic [58:0] exp_main(input logic [29:0] a, input logic [28:0] b);
        longint p;
        p = longint'($signed(a)) * longint'(b);
`ifdef WAVERFORMS_MUL_SAT_EN
        if (p > (64'sd1 <<< 57) - 64'sd1) return {1'b1, 58'h1FF_FFFF_FFFF_FFFF};
        if (p < -(64'sd1 <<< 57))         return {1'b1, 58'h200_0000_0000_0000};
`endif
        return {1'b0, p[57:0]};
    endfunction

    // Expected {ovf, dout} for the 57-bit instance.
    function automatic logic [57:0] exp_nar(input logic [29:0] a, input logic [28:0] b);
        longint p;
        p = longint'($signed(a)) * longint'(b);
`ifdef WAVERFORMS_MUL_SAT_EN
        if (p > (64'sd1 <<< 56) - 64'sd1) return {1'b1, 57'h0FF_FFFF_FFFF_FFFF};
        if (p < -(64'sd1 <<< 56))         return {1'b1, 57'h100_0000_0000_0000};
`endif
        return {1'b0, p[56:0]};
    endfunction

    // Expected {ovf, dout} for the signed x signed instance shifted right by 4.
    function automatic logic [58:0] exp_sh(input logic [29:0] a, input logic [28:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 4;
        return {1'b0, p[57:0]};
    endfunction

    // Scoreboard monitor, sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin
        if (!ap_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_occ", 64'(in_ready), 64'((qm.size() < 3) || out_ready));
            chk("busy_occ", 64'(busy), 64'(qm.size() != 0));
            if (prev_stall && out_valid)
                chk("stall_hold", 64'(dout), 64'(prev_dout));
            prev_stall = out_valid && !out_ready;
            prev_dout  = dout;
            if (out_valid && out_ready) begin
                if (qm.size() == 0) chk("main_unexpected_out", 64'(out_valid), 64'(0));
                else chk("main_result", 64'({ovf, dout}), 64'(qm.pop_front()));
            end
            if (n_out_valid && out_ready) begin
                if (qn.size() == 0) chk("nar_unexpected_out", 64'(n_out_valid), 64'(0));
                else chk("nar_result", 64'({n_ovf, n_dout}), 64'(qn.pop_front()));
            end
            if (s_out_valid && out_ready) begin
                if (qs.size() == 0) chk("sh_unexpected_out", 64'(s_out_valid), 64'(0));
                else chk("sh_result", 64'({s_ovf, s_dout}), 64'(qs.pop_front()));
            end
            if (in_valid && in_ready)   qm.push_back(exp_main(din0, din1));
            if (in_valid && n_in_ready) qn.push_back(exp_nar(din0, din1));
            if (in_valid && s_in_ready) qs.push_back(exp_sh(din0, din1));
        end
    end

    task automatic step();
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 12) begin
            step();
            n++;
        end
        if (!out_valid) chk(tag, 64'(out_valid), 64'(1));
    endtask

    task automatic drain(input string tag);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk(tag, 64'(qm.size()), 64'(0));
    endtask

    initial begin
        int i, g, nacc, t;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        ap_rst_n  = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        ap_rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'(1));

        // Basic product and latency.
        out_ready = 1'b1;
        din0 = 30'h3FFF_FFFD;   // -3
        din1 = 29'd5;
        in_valid = 1'b1;
        step();
        chk("lat_accept", 64'(acc), 64'(1));
        in_valid = 1'b0;
        step();
        chk("lat_early", 64'(out_valid), 64'(0));
        step();
        chk("lat_valid", 64'(out_valid), 64'(1));
        chk("neg3x5_dout", 64'(dout), 64'(58'h3FF_FFFF_FFFF_FFF1));
        chk("neg3x5_ovf", 64'(ovf), 64'(0));
        drain("drain_basic");

        // Overflow case on the narrow instance.
        din0 = 30'h2000_0000;   // -2^29
        din1 = 29'h1FFF_FFFF;   // 2^29-1
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out("ovf_timeout");
`ifdef WAVERFORMS_MUL_SAT_EN
        chk("nar_ovf_dout", 64'(n_dout), 64'(57'h100_0000_0000_0000));
        chk("nar_ovf_flag", 64'(n_ovf), 64'(1));
        chk("main_ovf_dout", 64'(dout), 64'(58'h200_0000_0000_0000));
        chk("main_ovf_flag", 64'(ovf), 64'(1));
`else
        chk("nar_wrap_dout", 64'(n_dout), 64'(57'h2000_0000));
        chk("nar_wrap_flag", 64'(n_ovf), 64'(0));
        chk("main_wrap_dout", 64'(dout), 64'(58'h2000_0000));
        chk("main_wrap_flag", 64'(ovf), 64'(0));
`endif
        drain("drain_ovf");

        // Arithmetic shift floor on the shifted instance.
        din0 = 30'h3FFF_FF9C;   // -100
        din1 = 29'd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out("shift_timeout");
        chk("shift_dout", 64'(s_dout), 64'(58'h3FF_FFFF_FFFF_FFF9));
        chk("shift_ovf", 64'(s_ovf), 64'(0));
        drain("drain_shift");

        // Stream of 20 incrementing samples with random backpressure.
        i = 0;
        g = 0;
        while (i < 20 && g < 400) begin
            t = i * 123457 - 1000000;
            din0 = t[29:0];
            din1 = 29'(i * 98765 + 1);
            in_valid  = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (acc) i++;
            g++;
        end
        chk("stream_all_accepted", 64'(i), 64'(20));
        drain("drain_stream");

        // Stall fill: out_ready low for 10 cycles with in_valid held high.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        nacc = 0;
        din0 = 30'd1000;
        din1 = 29'd3;
        repeat (10) begin
            step();
            if (acc) begin
                nacc++;
                din0 = din0 + 30'd17;
            end
        end
        chk("stall_accepts", 64'(nacc), 64'(3));
        chk("stall_busy", 64'(busy), 64'(1));
        chk("stall_ready_low", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        #1;
        chk("ready_returns", 64'(in_ready), 64'(1));
        step();
        chk("full_passthru_accept", 64'(acc), 64'(1));
        chk("full_passthru_busy", 64'(busy), 64'(1));
        drain("drain_stall");

        // Reset with two samples in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din0 = 30'd12;
        din1 = 29'd11;
        step();
        din0 = 30'd13;
        step();
        in_valid = 1'b0;
        step();
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_dout", 64'(dout), 64'(0));
        chk("midrst_ovf", 64'(ovf), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        qm.delete();
        qn.delete();
        qs.delete();
        out_ready = 1'b1;
        step();
        ap_rst_n = 1'b1;
        #1;
        chk("postrst_ready", 64'(in_ready), 64'(1));
        repeat (6) step();
        chk("postrst_no_stale", 64'(out_valid), 64'(0));
        din0 = 30'd7;
        din1 = 29'd9;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out("postrst_timeout");
        chk("postrst_product", 64'(dout), 64'(63));
        drain("drain_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
